fetch_queue: RTL and testbench

- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues one request per cycle to the synchronous instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- A branch redirect from EX flushes all buffered and in-flight fetches and restarts fetch at the target.

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with PC/instruction FIFO toward decode
//
// Purpose:
//   Owns the fetch PC, issues at most one request per cycle to a synchronous
//   instruction memory, buffers each returned word together with its PC and
//   presents the oldest entry to decode via a valid/ready handshake. A
//   redirect flushes the buffer and any in-flight fetch and restarts at the
//   (word-aligned) target.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   redirect_valid flush everything and restart fetch at redirect_pc
//   redirect_pc    restart address (low two bits ignored)
//   imem_req       a fetch is issued this cycle
//   imem_addr      fetch address (the fetch PC register)
//   imem_rdata     memory data, valid the cycle after the matching request
//   out_valid      FIFO head holds an instruction
//   out_ready      decode accepts the head this cycle
//   out_pc         PC of the head entry, 0 when empty
//   out_instr      instruction of the head entry, 0 when empty
//   occupancy      number of valid FIFO entries
module fetch_queue #(
  parameter int          PC_W     = 9,
  parameter int          INS_W    = 32,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INS_W-1:0]           out_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PC_W-1:0] RESET_PC_L = PC_W'(RESET_PC);

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  pending_pc_q, pending_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [PC_W-1:0]  pc_mem_q  [DEPTH];
  logic [INS_W-1:0] ins_mem_q [DEPTH];

  logic [CNT_W:0] credit_used;
  logic           push;
  logic           pop;

  // Credit counts buffered entries plus the one possibly in flight, so every
  // return is guaranteed a free slot. A same-cycle pop earns no credit.
  assign credit_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign imem_req    = !reset && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));

  // A return lands the cycle after its issue; a redirect in that cycle kills it.
  assign push = inflight_q && !redirect_valid;
  assign pop  = (count_q != '0) && out_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    inflight_d   = 1'b0;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~PC_W'(3);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);

      inflight_d = imem_req;
      if (imem_req) begin
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + PC_W'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC_L;
      pending_pc_q <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= pending_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]  : '0;
  assign out_instr = out_valid ? ins_mem_q[rd_ptr_q] : '0;
  assign occupancy = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-level model
module tb_fetch_queue;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             redirect_valid = 1'b0;
  logic [PC_W-1:0]  redirect_pc = '0;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;
  logic [2:0]       occupancy;

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Memory contents: a distinct recognisable word per address.
  function automatic logic [31:0] word(input logic [PC_W-1:0] a);
    return {7'h55, a, 7'h2A, ~a};
  endfunction

  // Reference model: the FIFO as a queue of entries plus one optional pending fetch.
  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } ent_t;

  ent_t            mq[$];
  logic [PC_W-1:0] m_fpc  = '0;
  logic [PC_W-1:0] m_pend = '0;
  bit              m_infl = 1'b0;
  bit              chk_en = 1'b0;

  function automatic bit m_req();
    return !redirect_valid && ((mq.size() + int'(m_infl)) < DEPTH);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fpc  = '0;
    m_pend = '0;
    m_infl = 1'b0;
  endtask

  task automatic model_update();
    bit req;
    req = m_req();
    if (redirect_valid) begin
      mq.delete();
      m_infl = 1'b0;
      m_fpc  = redirect_pc & 9'h1FC;
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (m_infl) mq.push_back('{m_pend, imem_rdata});
      if (req) begin
        m_pend = m_fpc;
        m_fpc  = m_fpc + 9'd4;
      end
      m_infl = req;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req",  32'(imem_req),  32'(m_req()));
      chk("imem_addr", 32'(imem_addr), 32'(m_fpc));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_pc",    32'(out_pc),    mq.size() != 0 ? 32'(mq[0].pc) : 32'd0);
      chk("out_instr", out_instr,      mq.size() != 0 ? mq[0].ins : 32'd0);
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
    end
  end

  // Drive this cycle's inputs (called just after a rising edge) and wait for the falling edge.
  task automatic step(input bit rdy, input bit rv, input logic [PC_W-1:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  // Close the cycle: let the model consume it, then answer the DUT's fetch.
  task automatic next_cycle();
    logic            r;
    logic [PC_W-1:0] a;
    r = imem_req;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (!reset) model_update();
    imem_rdata = r ? word(a) : $urandom();
  endtask

  task automatic run(input bit rdy, input bit rv, input logic [PC_W-1:0] rpc);
    step(rdy, rv, rpc);
    next_cycle();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    imem_rdata = $urandom();
    chk_en = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst occupancy", 32'(occupancy), 32'd0);
    chk("rst imem_req",  32'(imem_req),  32'd0);
    chk("rst out_pc",    32'(out_pc),    32'd0);
    chk("rst out_instr", out_instr,      32'd0);
    release_reset();

    // Streaming from reset with decode always ready.
    step(1, 0, 0);
    chk("t1 addr0", 32'(imem_addr), 32'd0);
    chk("t1 req0",  32'(imem_req),  32'd1);
    chk("t1 val0",  32'(out_valid), 32'd0);
    next_cycle();
    step(1, 0, 0);
    chk("t1 addr1", 32'(imem_addr), 32'd4);
    chk("t1 val1",  32'(out_valid), 32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("t1 valid", 32'(out_valid), 32'd1);
      chk("t1 pc",    32'(out_pc),    32'(i * 4));
      chk("t1 instr", out_instr,      word(9'(i * 4)));
      next_cycle();
    end

    // Stall until full, then drain without gaps.
    step(0, 1, 9'h000);
    chk("t2 redir req", 32'(imem_req), 32'd0);
    next_cycle();
    repeat (8) run(0, 0, 0);
    step(0, 0, 0);
    chk("t2 full occ", 32'(occupancy), 32'd4);
    chk("t2 full req", 32'(imem_req),  32'd0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      chk("t2 drain valid", 32'(out_valid), 32'd1);
      chk("t2 drain pc",    32'(out_pc),    32'(i * 4));
      next_cycle();
    end

    // Redirect to 0x40 with three buffered and one in flight.
    run(0, 1, 9'h000);
    repeat (4) run(0, 0, 0);
    step(0, 1, 9'h040);
    chk("t3 pre occ", 32'(occupancy), 32'd3);
    next_cycle();
    step(0, 0, 0);
    chk("t3 occ",   32'(occupancy), 32'd0);
    chk("t3 addr",  32'(imem_addr), 32'h40);
    chk("t3 req",   32'(imem_req),  32'd1);
    chk("t3 val1",  32'(out_valid), 32'd0);
    next_cycle();
    step(0, 0, 0);
    chk("t3 val2", 32'(out_valid), 32'd0);
    next_cycle();
    step(0, 0, 0);
    chk("t3 val3", 32'(out_valid), 32'd1);
    chk("t3 pc3",  32'(out_pc),    32'h40);
    next_cycle();

    // Misaligned redirect colliding with a pop and a return.
    repeat (6) run(1, 0, 0);
    step(1, 1, 9'h043);
    chk("t4 head valid", 32'(out_valid), 32'd1);
    chk("t4 redir req",  32'(imem_req),  32'd0);
    next_cycle();
    step(1, 0, 0);
    chk("t4 occ",  32'(occupancy), 32'd0);
    chk("t4 addr", 32'(imem_addr), 32'h40);
    next_cycle();
    run(1, 0, 0);
    step(1, 0, 0);
    chk("t4 pc", 32'(out_pc), 32'h40);
    next_cycle();

    // PC wrap-around at the top of the address space.
    run(1, 1, 9'h1FC);
    run(1, 0, 0);
    run(1, 0, 0);
    step(1, 0, 0);
    chk("t5 pc508", 32'(out_pc), 32'd508);
    next_cycle();
    step(1, 0, 0);
    chk("t5 pc0", 32'(out_pc), 32'd0);
    next_cycle();
    step(1, 0, 0);
    chk("t5 pc4", 32'(out_pc), 32'd4);
    next_cycle();

    // Asynchronous reset between clock edges.
    repeat (3) run(1, 0, 0);
    step(0, 0, 0);
    chk("t6 pre valid", 32'(out_valid), 32'd1);
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("t6 async valid", 32'(out_valid), 32'd0);
    chk("t6 async occ",   32'(occupancy), 32'd0);
    chk("t6 async req",   32'(imem_req),  32'd0);
    @(posedge clk);
    release_reset();
    step(1, 0, 0);
    chk("t6 restart addr", 32'(imem_addr), 32'd0);
    chk("t6 restart req",  32'(imem_req),  32'd1);
    next_cycle();
    run(1, 0, 0);
    step(1, 0, 0);
    chk("t6 restart pc", 32'(out_pc), 32'd0);
    next_cycle();

    // Randomised traffic with phases of differing back-pressure.
    for (int i = 0; i < 800; i++) begin
      int ready_pct;
      ready_pct = ((i / 100) % 2 == 0) ? 85 : 30;
      run($urandom_range(0, 99) < ready_pct,
          $urandom_range(0, 99) < 5,
          9'($urandom()));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
